// File: rtl/boot_loader.sv
// Boot loader: receives a program over a valid/ready byte stream (length,
// payload, XOR checksum), writes the payload into RAM from address 0 and
// releases the CPU only after the checksum matches.
`timescale 1ns/1ps
module boot_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              busy,
    output logic              cpu_run,
    output logic              error,
    output logic [ADDR_W:0]   bytes_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        CHK,
        DONE,
        ERROR
    } state_t;

    // Header lengths are compared one bit wider so DEPTH itself is representable.
    localparam logic [DATA_W:0] DEPTH_V = (DATA_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] acc;
    logic              accept;
    logic              restart;
    logic              last_byte;
    logic              hdr_zero;
    logic              hdr_big;

    // Write stage: one cycle behind the accepted payload byte.
    logic              we_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] data_p1;

    assign in_ready     = (state == HDR) || (state == LOAD) || (state == CHK);
    assign busy         = in_ready;
    assign cpu_run      = (state == DONE);
    assign error        = (state == ERROR);
    assign accept       = in_valid && in_ready;
    assign restart      = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign last_byte    = ((count + ONE) == len);
    assign hdr_zero     = (in_data == '0);
    assign hdr_big      = ({1'b0, in_data} > DEPTH_V);
    assign mem_we       = we_p1;
    assign mem_addr     = addr_p1;
    assign mem_data     = data_p1;
    assign bytes_loaded = count;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: header, payload and checksum phases of a load.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) state_next = HDR;
            end
            HDR: begin
                if (accept) begin
                    if (hdr_zero)     state_next = CHK;
                    else if (hdr_big) state_next = ERROR;
                    else              state_next = LOAD;
                end
            end
            LOAD: begin
                if (accept && last_byte) state_next = CHK;
            end
            CHK: begin
                if (accept) state_next = (in_data == acc) ? DONE : ERROR;
            end
            default: state_next = IDLE;
        endcase
    end

    // Length, payload count, running checksum and the registered RAM write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len     <= '0;
            count   <= '0;
            acc     <= '0;
            we_p1   <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            we_p1 <= 1'b0;
            if (restart) begin
                count <= '0;
                acc   <= '0;
            end else if (accept && (state == HDR)) begin
                len   <= in_data[ADDR_W:0];
                count <= '0;
                acc   <= '0;
            end else if (accept && (state == LOAD)) begin
                acc     <= acc ^ in_data;
                count   <= count + ONE;
                we_p1   <= 1'b1;
                addr_p1 <= count[ADDR_W-1:0];
                data_p1 <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a vector table for the single-cycle
// behaviour plus hand sequences for gaps, async reset and full-depth loads.
`timescale 1ns/1ps
module tb_boot_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [6:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_we;
    logic       busy;
    logic       cpu_run;
    logic       error;
    logic [7:0] bytes_loaded;

    int n_chk = 0;
    int n_bad = 0;

    // write log filled by the monitor
    int         wr_cnt = 0;
    logic [6:0] wa [256];
    logic [7:0] wd [256];

    boot_loader #(.DATA_W(8), .ADDR_W(7), .DEPTH(128)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_we(mem_we), .busy(busy), .cpu_run(cpu_run),
        .error(error), .bytes_loaded(bytes_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            wa[wr_cnt[7:0]] = mem_addr;
            wd[wr_cnt[7:0]] = mem_data;
            wr_cnt = wr_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       st;
        logic       vld;
        logic [7:0] d;
        logic       rdy;
        logic       we;
        logic [6:0] a;
        logic [7:0] wdat;
        logic       run;
        logic       err;
        logic [7:0] nb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic st, input logic vld, input logic [7:0] d,
                               input logic rdy, input logic we, input logic [6:0] a,
                               input logic [7:0] wdat, input logic run, input logic err,
                               input logic [7:0] nb);
        vec_t r;
        r.st = st; r.vld = vld; r.d = d; r.rdy = rdy; r.we = we; r.a = a;
        r.wdat = wdat; r.run = run; r.err = err; r.nb = nb;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_gap(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            step();
        end
        send(b);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int base;
        logic [7:0] x;
        logic [7:0] pb [3];
        int gaps [5];

        // reset state
        #12;
        chk("rst_we", mem_we, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_run", cpu_run, 0);
        chk("rst_err", error, 0);
        chk("rst_bytes", bytes_loaded, 0);
        rst_n = 1'b1;
        step();

        //             st vld d      rdy we a  wd     run err nb
        vecs.push_back(v(0, 1, 8'h55, 0, 0, 0, 8'h00, 0, 0, 0)); // IDLE ignores bytes
        vecs.push_back(v(1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0)); // -> HDR
        vecs.push_back(v(0, 1, 8'h03, 1, 0, 0, 8'h00, 0, 0, 0)); // L=3 -> LOAD
        vecs.push_back(v(0, 0, 8'hFF, 1, 0, 0, 8'h00, 0, 0, 0)); // gap
        vecs.push_back(v(0, 1, 8'h3C, 1, 1, 0, 8'h3C, 0, 0, 1));
        vecs.push_back(v(0, 1, 8'hA5, 1, 1, 1, 8'hA5, 0, 0, 2));
        vecs.push_back(v(0, 1, 8'h0F, 1, 1, 2, 8'h0F, 0, 0, 3)); // -> CHK
        vecs.push_back(v(0, 1, 8'h96, 0, 0, 0, 8'h00, 1, 0, 3)); // good -> DONE
        vecs.push_back(v(0, 1, 8'h12, 0, 0, 0, 8'h00, 1, 0, 3)); // DONE holds
        vecs.push_back(v(1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0)); // reload
        vecs.push_back(v(0, 1, 8'h01, 1, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(v(1, 1, 8'h7E, 1, 1, 0, 8'h7E, 0, 0, 1)); // start in LOAD ignored
        vecs.push_back(v(0, 1, 8'h7E, 0, 0, 0, 8'h00, 1, 0, 1));
        vecs.push_back(v(1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0)); // empty program
        vecs.push_back(v(0, 1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0)); // L=0 -> CHK
        vecs.push_back(v(0, 1, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0));
        vecs.push_back(v(1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(v(0, 1, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(v(0, 1, 8'h01, 0, 0, 0, 8'h00, 0, 1, 0)); // bad empty checksum
        vecs.push_back(v(1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(v(0, 1, 8'hC8, 0, 0, 0, 8'h00, 0, 1, 0)); // oversize
        vecs.push_back(v(0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0));
        vecs.push_back(v(1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(v(0, 1, 8'h02, 1, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(v(0, 1, 8'h10, 1, 1, 0, 8'h10, 0, 0, 1));
        vecs.push_back(v(0, 1, 8'h20, 1, 1, 1, 8'h20, 0, 0, 2));
        vecs.push_back(v(0, 1, 8'h31, 0, 0, 0, 8'h00, 0, 1, 2)); // checksum 0x30 expected
        vecs.push_back(v(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 2));

        foreach (vecs[i]) begin
            start    = vecs[i].st;
            in_valid = vecs[i].vld;
            in_data  = vecs[i].d;
            step();
            chk($sformatf("v%0d_ready", i), in_ready, vecs[i].rdy);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].rdy);
            chk($sformatf("v%0d_we", i), mem_we, vecs[i].we);
            if (vecs[i].we) begin
                chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].a);
                chk($sformatf("v%0d_data", i), mem_data, vecs[i].wdat);
            end
            chk($sformatf("v%0d_run", i), cpu_run, vecs[i].run);
            chk($sformatf("v%0d_err", i), error, vecs[i].err);
            chk($sformatf("v%0d_bytes", i), bytes_loaded, vecs[i].nb);
        end
        start = 1'b0;
        in_valid = 1'b0;

        // backpressure: same normal load with idle gaps between bytes
        pb[0] = 8'h3C; pb[1] = 8'hA5; pb[2] = 8'h0F;
        gaps[0] = 2; gaps[1] = 1; gaps[2] = 3; gaps[3] = 0; gaps[4] = 2;
        base = wr_cnt;
        pulse_start();
        send_gap(8'h03, gaps[0]);
        for (int i = 0; i < 3; i++) send_gap(pb[i], gaps[i+1]);
        send_gap(8'h96, 1);
        step();
        chk("bp_writes", wr_cnt - base, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_addr%0d", i), wa[(base+i) % 256], i);
            chk($sformatf("bp_data%0d", i), wd[(base+i) % 256], pb[i]);
        end
        chk("bp_run", cpu_run, 1);
        chk("bp_err", error, 0);
        chk("bp_bytes", bytes_loaded, 3);

        // async reset after the second payload byte
        pulse_start();
        send(8'h03);
        send(8'h3C);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        step();
        in_valid = 1'b0;
        chk("mid_we_before", mem_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_we_async", mem_we, 0);
        chk("mid_ready_async", in_ready, 0);
        chk("mid_busy_async", busy, 0);
        chk("mid_bytes_async", bytes_loaded, 0);
        #2 rst_n = 1'b1;
        base = wr_cnt;
        in_valid = 1'b1;
        in_data  = 8'h02;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post_rst_ready%0d", i), in_ready, 0);
            in_data = 8'($urandom);
        end
        in_valid = 1'b0;
        step();
        chk("post_rst_writes", wr_cnt - base, 0);
        chk("post_rst_run", cpu_run, 0);
        chk("post_rst_bytes", bytes_loaded, 0);

        // full-depth program L = DEPTH
        base = wr_cnt;
        x = 8'h00;
        pulse_start();
        send(8'h80);
        for (int i = 0; i < 128; i++) begin
            send(8'((i * 3 + 1) & 255));
            x = x ^ 8'((i * 3 + 1) & 255);
        end
        send(x);
        step();
        chk("full_writes", wr_cnt - base, 128);
        chk("full_first_addr", wa[base % 256], 0);
        chk("full_last_addr", wa[(base + 127) % 256], 127);
        chk("full_last_data", wd[(base + 127) % 256], 8'((127 * 3 + 1) & 255));
        chk("full_run", cpu_run, 1);
        chk("full_bytes", bytes_loaded, 128);

        // one past DEPTH is rejected
        base = wr_cnt;
        pulse_start();
        send(8'h81);
        chk("over_err", error, 1);
        chk("over_run", cpu_run, 0);
        chk("over_ready", in_ready, 0);
        step();
        chk("over_writes", wr_cnt - base, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Upstream stage of the processor's RAM: before the CPU runs, it receives a program as a byte stream over a valid/ready handshake and writes each byte into consecutive RAM words from address 0.
- Verifies the stream: length header first, payload next, XOR checksum last.
- Asserts cpu_run only when the load completes cleanly. The program counter and control unit stay held until then.

Parameters:
- DATA_W, 8, width of a stream byte, RAM word and processor bus.
- ADDR_W, 7, RAM address width.
- DEPTH, 128, number of RAM words (2**ADDR_W); the largest legal program length.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; starts a load from IDLE, DONE or ERROR.
- in_data  input  DATA_W  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_addr  output  ADDR_W  RAM write address.
- mem_data  output  DATA_W  RAM write data.
- mem_we  output  1  RAM write strobe, one cycle per payload byte.
- busy  output  1  load in progress (HDR, LOAD or CHK).
- cpu_run  output  1  program loaded and verified; releases the CPU.
- error  output  1  load failed (length too large or checksum mismatch).
- bytes_loaded  output  ADDR_W+1  payload bytes written in the current or last load.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE.
  - All outputs 0, including mem_we, which drops without waiting for a clock edge.
  - Length, count and XOR accumulator registers cleared.
- Transfer rule: a byte is accepted on a rising edge where in_valid = 1 and in_ready = 1.
  - in_valid while in_ready = 0 has no effect.
  - in_data may change freely while in_valid = 0.
- in_ready = 1 exactly in states HDR, LOAD and CHK (combinational decode of the state). busy equals in_ready.
- IDLE:
  - start moves to HDR.
  - Stream bytes are ignored.
- HDR: an accepted byte is the length L.
  - L = 0: go to CHK with accumulator 0.
  - L > DEPTH: go to ERROR.
  - Otherwise: go to LOAD with count = 0 and accumulator = 0.
  - bytes_loaded is cleared on entry to HDR.
- LOAD: for each accepted byte b:
  - acc <= acc ^ b.
  - Registered write issued the next cycle: mem_we = 1, mem_addr = count[ADDR_W-1:0], mem_data = b.
  - count and bytes_loaded increment.
  - When the accepted byte is the L-th, go to CHK.
  - Write latency is exactly 1 cycle after acceptance. Back-to-back accepts give back-to-back write strobes.
  - mem_we is 0 in every cycle that does not follow an accept.
- CHK: an accepted byte c is compared with acc.
  - Equal: go to DONE.
  - Not equal: go to ERROR.
  - The final payload write (mem_we in the first CHK cycle) still completes.
- DONE:
  - cpu_run = 1, error = 0.
  - Holds until reset or start.
  - start drops cpu_run on the next edge and goes to HDR (reload).
- ERROR:
  - error = 1, cpu_run = 0.
  - start clears error and goes to HDR.
  - bytes_loaded keeps the number of bytes actually written.
- start while in HDR, LOAD or CHK is ignored; the load continues.
- Address wrap cannot occur: L ≤ DEPTH, so count never exceeds DEPTH-1 as an address.
- L = DEPTH is legal: addresses 0..DEPTH-1 are written.
- cpu_run and error are never 1 simultaneously.
- cpu_run, error, busy and bytes_loaded are driven from registers or a pure state decode, so they are glitch-free.

Test Plan:
- Normal load: start; stream 0x03, 0x3C, 0xA5, 0x0F, 0x96 with in_valid held high -> writes (0,0x3C), (1,0xA5), (2,0x0F) on consecutive cycles; cpu_run = 1 the cycle after 0x96 is accepted; bytes_loaded = 3; error = 0.
- Empty program: start; stream 0x00, 0x00 -> no mem_we pulses; cpu_run = 1; bytes_loaded = 0. Repeat with stream 0x00, 0x01 -> error = 1.
- Oversize and bad checksum:
  - stream 0xC8 -> ERROR immediately, in_ready = 0, no writes.
  - new start, then 0x02, 0x10, 0x20, 0x31 -> two writes, error = 1, cpu_run = 0, bytes_loaded = 2.
- Backpressure gaps: normal-load stream with in_valid toggling 1,0,0,1,... and random idle gaps -> identical RAM writes and final state; one mem_we per accepted payload byte.
- Reset mid-load: deassert rst_n asynchronously after the 2nd payload byte -> mem_we, busy and in_ready drop at once; state IDLE; bytes arriving after reset release are ignored until start.
- Reload from DONE: after a good load, pulse start during DONE -> cpu_run falls the next edge; a fresh 1-byte program 0x01, 0x7E, 0x7E loads to address 0 and reasserts cpu_run. A start pulse during LOAD is ignored.
